// File: rtl/sdrc_rfsh_sched.sv
// SDRAM auto-refresh scheduler: interval timer, owed-refresh counter and a
// two-state request FSM that defers refreshes until the application is idle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no refresh requested; waiting for owed refreshes plus an
//          | idle application or urgency
// ST_REQ   | rfsh_req high; one auto-refresh is retired per rfsh_ack
module sdrc_rfsh_sched #(
  parameter int RFSH_TIMER_W = 12,
  parameter int RFSH_PEND_W  = 3
) (
  input  logic                    sdram_clk,
  input  logic                    reset_n,
  input  logic                    sdr_init_done,
  input  logic [RFSH_TIMER_W-1:0] cfg_sdr_rfsh,
  input  logic [RFSH_PEND_W-1:0]  cfg_sdr_rfmax,
  input  logic                    app_idle,
  input  logic                    rfsh_ack,
  output logic                    rfsh_req,
  output logic                    rfsh_urgent,
  output logic [RFSH_PEND_W-1:0]  rfsh_pend_cnt,
  output logic                    rfsh_ovf,
  output logic                    rfsh_err
);

  localparam logic [RFSH_TIMER_W-1:0] TIMER_ONE = 1;
  localparam logic [RFSH_PEND_W-1:0]  PEND_ONE  = 1;
  localparam logic [RFSH_PEND_W-1:0]  PEND_MAX  = '1;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t                  state_q, state_nxt;
  logic [RFSH_TIMER_W-1:0] timer_q;
  logic [RFSH_PEND_W-1:0]  pend_q, pend_nxt;
  logic                    timer_en, tick, valid_ack, ovf_set, urgent_nxt;

  assign timer_en  = sdr_init_done && (cfg_sdr_rfsh != '0);
  // Equality compare: a shrunk interval below the current count wraps the
  // timer through its full range rather than firing early.
  assign tick      = timer_en && (timer_q == (cfg_sdr_rfsh - TIMER_ONE));
  assign valid_ack = rfsh_ack && rfsh_req;

  assign rfsh_req      = (state_q == ST_REQ);
  assign rfsh_pend_cnt = pend_q;
  assign rfsh_urgent   = (cfg_sdr_rfmax != '0) && (pend_q >= cfg_sdr_rfmax);

  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (!timer_en || tick) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TIMER_ONE;
    end
  end

  always_comb begin
    pend_nxt = pend_q;
    ovf_set  = 1'b0;
    if (tick && !valid_ack) begin
      if (pend_q == PEND_MAX) ovf_set = 1'b1;
      else                    pend_nxt = pend_q + PEND_ONE;
    end else if (valid_ack && !tick && (pend_q != '0)) begin
      pend_nxt = pend_q - PEND_ONE;
    end
  end

  assign urgent_nxt = (cfg_sdr_rfmax != '0) && (pend_nxt >= cfg_sdr_rfmax);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if ((pend_q != '0) && (app_idle || rfsh_urgent)) state_nxt = ST_REQ;
      ST_REQ:  if (valid_ack && !((pend_nxt != '0) && (app_idle || urgent_nxt)))
                 state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (!sdr_init_done) state_nxt = ST_IDLE;
  end

  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
    end else if (!sdr_init_done) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_nxt;
      pend_q  <= pend_nxt;
    end
  end

  // Error flags are sticky across init_done drops; only reset clears them.
  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      rfsh_ovf <= 1'b0;
      rfsh_err <= 1'b0;
    end else begin
      if (ovf_set)                rfsh_ovf <= 1'b1;
      if (rfsh_ack && !rfsh_req) rfsh_err <= 1'b1;
    end
  end

endmodule
